// File: rtl/input_debouncer_if.sv
// Raw-input / debounced-output bundle of the input debouncer.
// The master drives raw and observes the debounced level and diagnostics.
interface input_debouncer_if #(
   parameter int GLITCH_W = 8
) ();
   logic                raw;
   logic                x;
   logic                busy;
   logic [GLITCH_W-1:0] glitches;

   modport master (output raw, input x, busy, glitches);
   modport slave  (input raw, output x, busy, glitches);
endinterface

// File: rtl/input_debouncer.sv
// Two-flop synchroniser followed by a four-state qualification FSM producing a
// clean registered level x, a busy flag and a saturating count of aborted changes.
module input_debouncer #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8,
   parameter int GLITCH_W      = 8
) (
   input  logic          clock,
   input  logic          reset_,
   input_debouncer_if.slave bus
);
   generate
      if ((STABLE_CYCLES < 2) || (STABLE_CYCLES > (2**CNT_W) - 1)) begin : g_bad_stable
         $error("input_debouncer: STABLE_CYCLES out of range 2..2**CNT_W-1");
      end
   endgenerate

   typedef enum logic [1:0] {LOW, QUAL_HIGH, HIGH, QUAL_LOW} state_t;

   localparam logic [CNT_W-1:0]    CNT_LAST    = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [GLITCH_W-1:0] GLITCH_MAX  = {GLITCH_W{1'b1}};

   logic [1:0]          sync_reg;
   logic                s;
   state_t              state_reg, state_next;
   logic [CNT_W-1:0]    cnt_reg, cnt_next;
   logic                x_reg, x_next;
   logic                busy_reg, busy_next;
   logic [GLITCH_W-1:0] glitches_reg;
   logic                glitch_inc;

   assign s = sync_reg[1];

   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         sync_reg     <= 2'b00;
         state_reg    <= LOW;
         cnt_reg      <= '0;
         x_reg        <= 1'b0;
         busy_reg     <= 1'b0;
         glitches_reg <= '0;
      end else begin
         sync_reg  <= {sync_reg[0], bus.raw};
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         x_reg     <= x_next;
         busy_reg  <= busy_next;
         // Saturate instead of wrapping so a noisy line never looks quiet again.
         if (glitch_inc && (glitches_reg != GLITCH_MAX))
            glitches_reg <= glitches_reg + GLITCH_W'(1);
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      glitch_inc = 1'b0;
      case (state_reg)
         LOW: begin
            if (s) begin
               state_next = QUAL_HIGH;
               cnt_next   = CNT_W'(1);
            end
         end
         QUAL_HIGH: begin
            if (!s) begin
               state_next = LOW;
               cnt_next   = '0;
               glitch_inc = 1'b1;
            end else if (cnt_reg == CNT_LAST) begin
               state_next = HIGH;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         HIGH: begin
            if (!s) begin
               state_next = QUAL_LOW;
               cnt_next   = CNT_W'(1);
            end
         end
         QUAL_LOW: begin
            if (s) begin
               state_next = HIGH;
               cnt_next   = '0;
               glitch_inc = 1'b1;
            end else if (cnt_reg == CNT_LAST) begin
               state_next = LOW;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         default: begin
            state_next = LOW;
            cnt_next   = '0;
         end
      endcase
      // Outputs are registered copies of the next-state decode.
      x_next    = (state_next == HIGH)      || (state_next == QUAL_LOW);
      busy_next = (state_next == QUAL_HIGH) || (state_next == QUAL_LOW);
   end

   assign bus.x        = x_reg;
   assign bus.busy     = busy_reg;
   assign bus.glitches = glitches_reg;
endmodule

// File: tb/tb_input_debouncer.sv
// Directed and randomized checks of input_debouncer against a run-length model;
// a second instance with GLITCH_W=2 exercises counter saturation.
module tb_input_debouncer;
   localparam int STABLE = 4;

   logic clock  = 1'b0;
   logic reset_ = 1'b0;

   input_debouncer_if #(.GLITCH_W(8)) bus8 ();
   input_debouncer_if #(.GLITCH_W(2)) bus2 ();

   input_debouncer #(.STABLE_CYCLES(STABLE), .CNT_W(8), .GLITCH_W(8)) dut (
      .clock(clock), .reset_(reset_), .bus(bus8));
   input_debouncer #(.STABLE_CYCLES(STABLE), .CNT_W(8), .GLITCH_W(2)) dut_sat (
      .clock(clock), .reset_(reset_), .bus(bus2));

   always #5 clock = ~clock;

   int n_vec = 0;
   int n_err = 0;

   // Model: s is raw delayed by two edges; x flips after STABLE consecutive
   // samples that disagree with it; an interrupted run counts as a glitch.
   logic m_d1, m_d2;
   logic m_x;
   int   m_run;
   int   m_glitch;
   int   rises;
   logic prev_x;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_d1 = 0; m_d2 = 0; m_x = 0; m_run = 0; m_glitch = 0;
   endtask

   task automatic model_step(input logic r);
      logic s;
      s    = m_d2;
      m_d2 = m_d1;
      m_d1 = r;
      if (s != m_x) begin
         m_run++;
         if (m_run == STABLE) begin
            m_x   = s;
            m_run = 0;
         end
      end else begin
         if (m_run > 0) m_glitch++;
         m_run = 0;
      end
   endtask

   task automatic check_all();
      chk("x",         32'(bus8.x),        32'(m_x));
      chk("busy",      32'(bus8.busy),     32'(m_run > 0));
      chk("glitches",  32'(bus8.glitches), 32'((m_glitch > 255) ? 255 : m_glitch));
      chk("x_w2",      32'(bus2.x),        32'(m_x));
      chk("busy_w2",   32'(bus2.busy),     32'(m_run > 0));
      chk("glitch_w2", 32'(bus2.glitches), 32'((m_glitch > 3) ? 3 : m_glitch));
   endtask

   // One clock: drive raw, take the edge, check 1 time unit later.
   task automatic tick(input logic r);
      bus8.raw = r;
      bus2.raw = r;
      @(posedge clock);
      if (reset_) model_step(r);
      #1;
      if (bus8.x === 1'b1 && prev_x === 1'b0) rises++;
      prev_x = bus8.x;
      check_all();
   endtask

   int g_before;
   int rises_before;
   int seg_len;
   logic seg_val;

   initial begin
      model_reset();
      rises  = 0;
      prev_x = 1'b0;

      // 1: reset held with raw=1, then full latency after release
      reset_ = 1'b0;
      for (int i = 0; i < 3; i++) tick(1'b1);
      chk("t1_rst_x", 32'(bus8.x), 32'd0);
      reset_ = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         tick(1'b1);
         chk("t1_latency_x", 32'(bus8.x), 32'(i >= 6));
      end

      // 2: clean rise from a settled low
      for (int i = 0; i < 8; i++) tick(1'b0);
      rises_before = rises;
      for (int i = 1; i <= 7; i++) begin
         tick(1'b1);
         chk("t2_x",    32'(bus8.x),    32'(i >= 6));
         chk("t2_busy", 32'(bus8.busy), 32'(i >= 3 && i <= 5));
      end
      chk("t2_glitches", 32'(bus8.glitches), 32'd0);
      chk("t2_impulses", 32'(rises - rises_before), 32'd1);

      // 3: two-cycle bounce from x=0
      for (int i = 0; i < 8; i++) tick(1'b0);
      g_before     = int'(bus8.glitches);
      rises_before = rises;
      tick(1'b1); tick(1'b1);
      for (int i = 1; i <= 6; i++) begin
         tick(1'b0);
         chk("t3_x", 32'(bus8.x), 32'd0);
         // zero reaches s2 after the 2nd zero edge; busy drops one edge later
         if (i == 2) chk("t3_busy_hold", 32'(bus8.busy), 32'd1);
         if (i == 3) chk("t3_busy_drop", 32'(bus8.busy), 32'd0);
      end
      chk("t3_glitches", 32'(bus8.glitches), 32'(g_before + 1));
      chk("t3_impulses", 32'(rises - rises_before), 32'd0);

      // 4: clean fall, then a late single-cycle 1 during QUAL_LOW
      for (int i = 0; i < 8; i++) tick(1'b1);
      for (int i = 1; i <= 7; i++) begin
         tick(1'b0);
         chk("t4_fall_x", 32'(bus8.x), 32'(i < 6));
      end
      for (int i = 0; i < 8; i++) tick(1'b1);
      g_before = int'(bus8.glitches);
      tick(1'b0); tick(1'b0); tick(1'b0);
      for (int i = 0; i < 6; i++) begin
         tick(1'b1);
         chk("t4_hold_x", 32'(bus8.x), 32'd1);
      end
      chk("t4_glitches", 32'(bus8.glitches), 32'(g_before + 1));

      // 5: saturation of the 2-bit counter
      reset_ = 1'b0;
      model_reset();
      tick(1'b0);
      reset_ = 1'b1;
      for (int b = 1; b <= 5; b++) begin
         tick(1'b1); tick(1'b1);
         for (int i = 0; i < 6; i++) tick(1'b0);
         chk("t5_sat", 32'(bus2.glitches), 32'((b > 3) ? 3 : b));
      end

      // 6: reset in the middle of a rise qualification
      for (int i = 0; i < 4; i++) tick(1'b1);
      chk("t6_busy_before", 32'(bus8.busy), 32'd1);
      reset_ = 1'b0;
      #1;
      chk("t6_async_x",    32'(bus8.x),    32'd0);
      chk("t6_async_busy", 32'(bus8.busy), 32'd0);
      model_reset();
      tick(1'b1); tick(1'b1);
      reset_ = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         tick(1'b1);
         chk("t6_latency_x", 32'(bus8.x), 32'(i >= 6));
      end

      // Randomized segments of random value and hold length
      for (int seg = 0; seg < 80; seg++) begin
         seg_val = 1'($urandom_range(0, 1));
         seg_len = int'($urandom_range(1, 7));
         for (int i = 0; i < seg_len; i++) tick(seg_val);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
